// File: rtl/path_pkg.sv
// Shared definitions for the path stream reader: geometry of the packed
// path words, the end-of-path sentinel, FSM state encodings and the
// node extraction helper used by the node mux.
package path_pkg;

    localparam int NODE_W         = 5;
    localparam int NUM_WORDS      = 9;
    localparam int NODES_PER_WORD = 6;
    localparam int WORD_W         = 32;
    localparam int MAX_NODES      = NUM_WORDS * NODES_PER_WORD;
    localparam int IDX_W          = $clog2(MAX_NODES + 1);
    localparam int BUF_W          = WORD_W * NUM_WORDS;

    localparam logic [NODE_W-1:0] NODE_SENTINEL = 5'h1F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOW  = 3'd1,
        WAIT_HIGH = 3'd2,
        STREAM    = 3'd3,
        FINISH    = 3'd4
    } path_state_e;

    // Plain vector encodings for the state register.
    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_WAIT_LOW  = WAIT_LOW;
    localparam logic [2:0] ST_WAIT_HIGH = WAIT_HIGH;
    localparam logic [2:0] ST_STREAM    = STREAM;
    localparam logic [2:0] ST_FINISH    = FINISH;

    // Node n lives in word n/6 at bit offset 5*(n%6); bits [31:30] of each
    // word are never selected. Indices past the last node read as the
    // sentinel so a look-ahead at n+1 off the end terminates the path.
    function automatic logic [NODE_W-1:0] node_at(input logic [BUF_W-1:0] path_buf,
                                                  input logic [IDX_W-1:0] n);
        logic [NODE_W-1:0] node;
        node = NODE_SENTINEL;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (n == IDX_W'(i))
                node = path_buf[WORD_W*(i/NODES_PER_WORD) + NODE_W*(i%NODES_PER_WORD) +: NODE_W];
        end
        return node;
    endfunction

endpackage

// File: rtl/path_node_mux.sv
// Selects the current node and its successor from the captured path buffer
// and decodes whether the current node is the final beat of the stream.
module path_node_mux
    import path_pkg::*;
(
    input  logic [BUF_W-1:0]  path_buf,
    input  logic [IDX_W-1:0]  n,
    input  logic [NODE_W-1:0] ep,
    output logic [NODE_W-1:0] node_cur,
    output logic              is_last
);

    logic [NODE_W-1:0] node_nxt;

    // Current/next node lookup and end-of-path decode.
    always_comb begin
        node_cur = node_at(path_buf, n);
        node_nxt = node_at(path_buf, n + IDX_W'(1));
        is_last  = (node_cur == ep)
                || (n == IDX_W'(MAX_NODES - 1))
                || (node_nxt == NODE_SENTINEL);
    end

endmodule

// File: rtl/path_stream_reader.sv
// Host-side path reader: drives SP/EP to the path-planning CPU, waits for a
// fresh path_found, captures the packed path words and replays them as a
// valid/ready stream of node IDs.
//
// Optional build macro PATH_SP_CHECK_EN: when defined, a captured path whose
// first node differs from SP is rejected with sticky sp_mismatch_err and no
// beats are emitted.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start; SP/EP hold last request
// WAIT_LOW  | ignoring a stale path_found from a previous request
// WAIT_HIGH | waiting for the CPU to raise path_found; captures words
// STREAM    | presenting node n on the stream
// FINISH    | one-cycle done pulse
module path_stream_reader
    import path_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
)
(
    input  logic                      clk_50M,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NODE_W-1:0]         sp_req,
    input  logic [NODE_W-1:0]         ep_req,
    output logic [NODE_W-1:0]         SP,
    output logic [NODE_W-1:0]         EP,
    input  logic                      path_found,
    input  logic [WORD_W*NUM_WORDS-1:0] path_words,
    output logic                      node_valid,
    input  logic                      node_ready,
    output logic [NODE_W-1:0]         node_data,
    output logic                      node_last,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err
`ifdef PATH_SP_CHECK_EN
    ,
    output logic                      sp_mismatch_err
`endif
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state;
    logic [TMR_W-1:0]  tmr;
    logic [IDX_W-1:0]  n;
    logic [BUF_W-1:0]  path_buf;
    logic [NODE_W-1:0] node_cur;
    logic              is_last;
    logic [NODE_W-1:0] first_node;
    logic              beat;

    // Node 0 checks are made on the live words in the capture cycle so an
    // empty or rejected path never shows a valid beat.
    assign first_node = path_words[NODE_W-1:0];
    assign beat       = node_valid && node_ready;

    path_node_mux u_node_mux (
        .path_buf (path_buf),
        .n        (n),
        .ep       (EP),
        .node_cur (node_cur),
        .is_last  (is_last)
    );

    // Request/capture/stream sequencing with a down-counting wait timer.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            SP          <= '0;
            EP          <= '0;
            timeout_err <= 1'b0;
            tmr         <= '0;
            n           <= '0;
            path_buf    <= '0;
`ifdef PATH_SP_CHECK_EN
            sp_mismatch_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        SP          <= sp_req;
                        EP          <= ep_req;
                        timeout_err <= 1'b0;
`ifdef PATH_SP_CHECK_EN
                        sp_mismatch_err <= 1'b0;
`endif
                        tmr         <= TMR_LOAD;
                        n           <= '0;
                        state       <= ST_WAIT_LOW;
                    end
                end
                ST_WAIT_LOW: begin
                    if (tmr == '0) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                        if (!path_found)
                            state <= ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (path_found) begin
                        path_buf <= path_words;
                        n        <= '0;
`ifdef PATH_SP_CHECK_EN
                        if (first_node != SP) begin
                            sp_mismatch_err <= 1'b1;
                            state           <= ST_IDLE;
                        end else
`endif
                        if (first_node == NODE_SENTINEL)
                            state <= ST_FINISH;
                        else
                            state <= ST_STREAM;
                    end else if (tmr == '0) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                ST_STREAM: begin
                    if (beat) begin
                        if (is_last)
                            state <= ST_FINISH;
                        else
                            n <= n + IDX_W'(1);
                    end
                end
                ST_FINISH: begin
                    n     <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stream and status outputs decode straight from the state register so
    // an async reset drops them immediately.
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_FINISH);
    assign node_valid = (state == ST_STREAM);
    assign node_data  = node_valid ? node_cur : '0;
    assign node_last  = node_valid && is_last;

endmodule
